// File: rtl/nand_emu_pkg.sv
// nand_emu_pkg: opcodes, page geometry and FSM state encoding for the NAND flash emulator.
package nand_emu_pkg;
  localparam logic [7:0] CMD_RD0  = 8'h00;
  localparam logic [7:0] CMD_RD1  = 8'h01;
  localparam logic [7:0] CMD_PROG = 8'h80;
  localparam logic [7:0] CMD_CONF = 8'h10;
  localparam logic [7:0] CMD_RST  = 8'hFF;
  localparam logic [7:0] CMD_STAT = 8'h70;
  localparam int PAGE_BYTES = 512;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_BUSY, S_RD_OUT, S_PG_DATA, S_PG_BUSY, S_RST_BUSY
  } state_t;
endpackage

// File: rtl/nand_emu_ram.sv
// nand_emu_ram: single-clock byte RAM, one synchronous write port, one asynchronous read port.
module nand_emu_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/nand_flash_emu.sv
// nand_flash_emu: NAND device emulator with a 512-byte page register and 2^PAGE_AW-page array.
// Define NAND_STATUS_EN to enable the 0x70 read-status command.
module nand_flash_emu
  import nand_emu_pkg::*;
#(
  parameter int PAGE_AW = 2,
  parameter int T_EXTRA = 4,
  parameter int T_RST   = 8
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB
);
  localparam int CW = $clog2(PAGE_BYTES + T_EXTRA + T_RST);
  localparam logic [CW-1:0] C_PG = CW'(PAGE_BYTES);
  localparam logic [CW-1:0] C_CP = CW'(PAGE_BYTES + T_EXTRA - 1);
  localparam logic [CW-1:0] C_RS = CW'(T_RST - 1);
  state_t r_state;
  logic r_wen_q, r_ren_q, r_prog, r_half, r_rb;
  logic [1:0] r_acnt;
  logic [8:0] r_col;
  logic [PAGE_AW-1:0] r_page;
  logic [CW-1:0] r_cnt;
  logic [PAGE_BYTES-1:0] r_vld;
  logic w_wr, w_cmd, w_adr, w_dat, w_adv, w_busy, w_cp, w_op, w_clr;
  logic w_stat, w_scmd, w_rdcp, w_pgcp, w_pwe, w_drv;
  logic [8:0] w_pra, w_pwa;
  logic [7:0] w_preg_q, w_arr_q, w_preg_rd, w_pwd, w_dout;
  logic [PAGE_AW+8:0] w_aa;
  assign w_wr   = r_wen_q & ~F_WEN;
  assign w_cmd  = w_wr & F_CLE & ~F_ALE;
  assign w_adr  = w_wr & ~F_CLE & F_ALE;
  assign w_dat  = w_wr & ~F_CLE & ~F_ALE;
  assign w_adv  = ~r_ren_q & F_REN;
  assign w_busy = r_state inside {S_RD_BUSY, S_PG_BUSY, S_RST_BUSY};
  assign w_cp   = r_cnt < C_PG;
  assign w_op   = w_cmd & ~w_scmd;
  assign w_clr  = w_op & ~w_busy & (F_IO == CMD_PROG);
`ifdef NAND_STATUS_EN
  logic r_stat;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_stat <= 1'b0;
    else if (w_cmd) r_stat <= (F_IO == CMD_STAT);
  assign w_stat = r_stat;
  assign w_scmd = w_cmd & (F_IO == CMD_STAT);
`else
  assign w_stat = 1'b0;
  assign w_scmd = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= S_IDLE;
      r_rb    <= 1'b1;
      r_col   <= '0;
      r_half  <= 1'b0;
      r_prog  <= 1'b0;
      r_acnt  <= '0;
      r_page  <= '0;
      r_cnt   <= '0;
      r_wen_q <= 1'b1;
      r_ren_q <= 1'b1;
    end else begin
      r_wen_q <= F_WEN;
      r_ren_q <= F_REN;
      r_cnt   <= r_cnt + CW'(1);
      if (w_busy && w_op && F_IO == CMD_RST) begin
        r_state <= S_RST_BUSY;
        r_cnt   <= '0;
      end else if (w_op && !w_busy) begin
        r_state <= S_IDLE;
        if (F_IO == CMD_RD0 || F_IO == CMD_RD1) r_half <= F_IO[0];
        if (F_IO == CMD_PROG) begin
          r_state <= S_ADDR;
          r_prog  <= 1'b1;
          r_acnt  <= '0;
        end
        if (F_IO == CMD_CONF && r_state == S_PG_DATA) begin
          r_state <= S_PG_BUSY;
          r_cnt   <= '0;
          r_half  <= 1'b0;
          r_rb    <= 1'b0;
        end
        if (F_IO == CMD_RST) begin
          r_state <= S_RST_BUSY;
          r_cnt   <= '0;
          r_rb    <= 1'b0;
        end
      end else
        case (r_state)
          S_IDLE: if (w_adr) begin
            r_col   <= {r_half, F_IO};
            r_prog  <= 1'b0;
            r_acnt  <= 2'd1;
            r_state <= S_ADDR;
          end
          // the third cycle carries page[8], beyond the kept PAGE_AW bits
          S_ADDR: if (w_adr) begin
            r_acnt <= r_acnt + 2'd1;
            if (r_acnt == 2'd0) r_col <= {r_half, F_IO};
            if (r_acnt == 2'd1) r_page <= F_IO[PAGE_AW-1:0];
            if (r_acnt == 2'd2) begin
              r_state <= r_prog ? S_PG_DATA : S_RD_BUSY;
              r_cnt   <= '0;
              r_half  <= r_prog & r_half;
              r_rb    <= r_prog;
            end
          end
          S_RD_BUSY: if (r_cnt == C_CP) begin
            r_state <= S_RD_OUT;
            r_rb    <= 1'b1;
          end
          S_RD_OUT:  if (w_adv && !w_stat) r_col <= r_col + 9'd1;
          S_PG_DATA: if (w_dat) r_col <= r_col + 9'd1;
          S_PG_BUSY: if (r_cnt == C_CP) begin
            r_state <= S_IDLE;
            r_rb    <= 1'b1;
          end
          S_RST_BUSY: if (r_cnt == C_RS) begin
            r_state <= S_IDLE;
            r_rb    <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
    end
  // 0x80 "clears" the page register by invalidating every byte; invalid bytes read as 0xFF
  always_ff @(posedge clk)
    if (w_clr) r_vld <= '0;
    else if (w_pwe) r_vld[w_pwa] <= 1'b1;
  assign w_rdcp    = (r_state == S_RD_BUSY) & w_cp;
  assign w_pgcp    = (r_state == S_PG_BUSY) & w_cp;
  assign w_pwe     = w_rdcp | ((r_state == S_PG_DATA) & w_dat);
  assign w_pwa     = w_rdcp ? r_cnt[8:0] : r_col;
  assign w_pwd     = w_rdcp ? w_arr_q : F_IO;
  assign w_pra     = (r_state == S_PG_BUSY) ? r_cnt[8:0] : r_col;
  assign w_preg_rd = r_vld[w_pra] ? w_preg_q : 8'hFF;
  assign w_aa      = {r_page, r_cnt[8:0]};
  assign w_dout    = w_stat ? {1'b1, r_rb, 6'b0} : w_preg_rd;
  assign w_drv     = ~F_REN & F_WEN & (w_stat | (r_state == S_RD_OUT));
  assign F_IO      = w_drv ? w_dout : 8'bz;
  assign F_RB      = r_rb;
  nand_emu_ram #(.AW(9)) u_preg (
    .clk(clk), .i_we(w_pwe), .i_waddr(w_pwa), .i_wdata(w_pwd),
    .i_raddr(w_pra), .o_rdata(w_preg_q)
  );
  nand_emu_ram #(.AW(PAGE_AW + 9)) u_arr (
    .clk(clk), .i_we(w_pgcp), .i_waddr(w_aa), .i_wdata(w_preg_rd),
    .i_raddr(w_aa), .o_rdata(w_arr_q)
  );
endmodule

// File: tb/tb_nand_flash_emu.sv
// tb_nand_flash_emu: directed self-checking bench for nand_flash_emu.
module tb_nand_flash_emu;
  localparam int BUSY = 516;
  localparam int RSTB = 8;
`ifdef NAND_STATUS_EN
  localparam logic [7:0] E_BUSY = 8'h80, E_RDY = 8'hC0;
`else
  localparam logic [7:0] E_BUSY = 8'hFF, E_RDY = 8'hA1;
`endif
  logic clk, rst, F_CLE, F_ALE, F_WEN, F_REN, oe;
  logic F_RB;
  logic [7:0] dq, v;
  wire  [7:0] F_IO;
  int n_chk, n_fail, len;
  assign F_IO = oe ? dq : 8'bz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (F_IO[i]);
  end
  nand_flash_emu dut (
    .clk(clk), .rst(rst), .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE),
    .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic c, input logic a, input logic [7:0] d);
    F_CLE = c; F_ALE = a; dq = d; oe = 1'b1; F_WEN = 1'b0;
    tick();
    F_WEN = 1'b1; oe = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
    tick();
  endtask
  task automatic wr_meas(input logic c, input logic a, input logic [7:0] d, output int n);
    F_CLE = c; F_ALE = a; dq = d; oe = 1'b1; F_WEN = 1'b0;
    tick();
    F_WEN = 1'b1; oe = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (F_RB) break;
      n++;
    end
    tick();
  endtask
  task automatic rd(output logic [7:0] b);
    F_REN = 1'b0;
    @(negedge clk); b = F_IO;
    tick();
    F_REN = 1'b1;
    tick();
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; F_WEN = 1'b1; F_REN = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0; oe = 1'b0; dq = '0;
    repeat (3) tick();
    chk("reset_rb", 16'(F_RB), 16'h1);
    rst = 1'b1; tick();
    wr(1, 0, 8'h80); wr(0, 1, 8'h05);
    #2 rst = 1'b0;
    tick();
    chk("midreset_rb", 16'(F_RB), 16'h1);
    rst = 1'b1; tick();
    F_REN = 1'b0;
    @(negedge clk); chk("reset_io_z", 16'(F_IO), 16'h00FF);
    tick(); F_REN = 1'b1; tick();
    wr_meas(1, 0, 8'hFF, len);
    chk("rst_cmd_busy", 16'(len), 16'(RSTB));
    wr(1, 0, 8'h80); wr(0, 1, 8'h05); wr(0, 1, 8'h01); wr(0, 1, 8'h00);
    wr(0, 0, 8'hA1); wr(0, 0, 8'hA2); wr(0, 0, 8'hA3); wr(0, 0, 8'hA4);
    wr_meas(1, 0, 8'h10, len);
    chk("prog_busy", 16'(len), 16'(BUSY));
    wr(1, 0, 8'h00); wr(0, 1, 8'h05); wr(0, 1, 8'h01);
    wr_meas(0, 1, 8'h00, len);
    chk("read_busy", 16'(len), 16'(BUSY));
    F_CLE = 1'b1; F_ALE = 1'b1; F_WEN = 1'b0; F_REN = 1'b0;
    @(negedge clk); chk("wen_ren_z", 16'(F_IO), 16'h00FF);
    tick(); F_WEN = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0;
    @(negedge clk); chk("rd_a1", 16'(F_IO), 16'h00A1);
    tick(); F_REN = 1'b1; tick();
    rd(v); chk("rd_a2", 16'(v), 16'h00A2);
    rd(v); chk("rd_a3", 16'(v), 16'h00A3);
    rd(v); chk("rd_a4", 16'(v), 16'h00A4);
    wr(1, 0, 8'h01); wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h02); wr(0, 1, 8'h00);
    wr(0, 0, 8'h5A);
    wr_meas(1, 0, 8'h10, len);
    chk("prog2_busy", 16'(len), 16'(BUSY));
    wr(1, 0, 8'h01); wr(0, 1, 8'h00); wr(0, 1, 8'h02); wr_meas(0, 1, 8'h00, len);
    rd(v); chk("half1_5a", 16'(v), 16'h005A);
    wr(1, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h02); wr_meas(0, 1, 8'h00, len);
    rd(v); chk("half0_ff", 16'(v), 16'h00FF);
    wr(1, 0, 8'h01); wr(1, 0, 8'h80); wr(0, 1, 8'hFF); wr(0, 1, 8'h03); wr(0, 1, 8'h00);
    wr(0, 0, 8'hC1); wr(0, 0, 8'hC2); wr(0, 0, 8'hC3);
    wr_meas(1, 0, 8'h10, len);
    wr(1, 0, 8'h01); wr(0, 1, 8'hFF); wr(0, 1, 8'h03); wr_meas(0, 1, 8'h00, len);
    rd(v); chk("wrap_511", 16'(v), 16'h00C1);
    rd(v); chk("wrap_0", 16'(v), 16'h00C2);
    rd(v); chk("wrap_1", 16'(v), 16'h00C3);
    wr(1, 0, 8'h80); wr(0, 1, 8'h00); wr(0, 1, 8'h00); wr(0, 1, 8'h00);
    wr(0, 0, 8'hD1); wr(0, 0, 8'hD2);
    wr(1, 0, 8'h10);
    wr(1, 0, 8'h00); wr(1, 0, 8'h01); wr(1, 0, 8'h80);
    repeat (93) tick();
    chk("abort_still_busy", 16'(F_RB), 16'h0);
    wr_meas(1, 0, 8'hFF, len);
    chk("abort_rst_busy", 16'(len), 16'(RSTB));
    wr(0, 1, 8'h00); wr(0, 1, 8'h00); wr_meas(0, 1, 8'h00, len);
    rd(v); chk("abort_d1", 16'(v), 16'h00D1);
    rd(v); chk("abort_d2", 16'(v), 16'h00D2);
    wr(1, 0, 8'h00); wr(0, 1, 8'h05); wr(0, 1, 8'h01); wr(0, 1, 8'h00);
    wr(1, 0, 8'h70);
    F_REN = 1'b0;
    @(negedge clk); chk("status_busy", 16'(F_IO), 16'(E_BUSY));
    tick(); F_REN = 1'b1; tick();
    len = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (F_RB) break;
      len++;
    end
    chk("status_wait_ready", 16'(F_RB), 16'h1);
    tick();
    F_REN = 1'b0;
    @(negedge clk); chk("status_ready", 16'(F_IO), 16'(E_RDY));
    tick(); F_REN = 1'b1; tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
